// File: rtl/seq_issuer.sv
// Issue controller for the five-stage sequencer: accepts a run request, pulses start, counts WB stages, pulses done.
// Optional SEQ_ISSUER_CHECK_EN adds a stage-order checker that sets a sticky err and aborts the run.
module seq_issuer #(
    parameter int CNT_W = 8
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_count,
    output logic             req_ready,
    input  logic [2:0]       state_in,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] retired,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [2:0] STG_IF = 3'd1;
    localparam logic [2:0] STG_WB = 3'd5;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] retired_inc;
    logic             accept;

`ifdef SEQ_ISSUER_CHECK_EN
    logic [2:0] exp_q, exp_d;
    logic       err_q, err_d;
`endif

    // Outputs decode registered state only, so inputs never reach them combinationally.
    assign req_ready   = (state_q == S_IDLE);
    assign start       = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign retired     = retired_q;
    assign accept      = req_valid && (state_q == S_IDLE);
    assign retired_inc = retired_q + CNT_W'(1);

`ifdef SEQ_ISSUER_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        retired_d = retired_q;
        done_d    = 1'b0;
`ifdef SEQ_ISSUER_CHECK_EN
        exp_d     = exp_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    target_d  = req_count;
                    retired_d = '0;
`ifdef SEQ_ISSUER_CHECK_EN
                    err_d     = 1'b0;
`endif
                    if (req_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_RUN;
`ifdef SEQ_ISSUER_CHECK_EN
                exp_d   = STG_IF;
`endif
            end
            S_RUN: begin
`ifdef SEQ_ISSUER_CHECK_EN
                if (state_in != exp_q) begin
                    // Out-of-order stage: abort the run, keep the count reached so far.
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    exp_d = (exp_q == STG_WB) ? STG_IF : exp_q + 3'd1;
                    if (state_in == STG_WB) begin
                        retired_d = retired_inc;
                        if (retired_inc == target_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
`else
                if (state_in == STG_WB) begin
                    retired_d = retired_inc;
                    if (retired_inc == target_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            retired_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            retired_q <= retired_d;
            done_q    <= done_d;
        end
    end

`ifdef SEQ_ISSUER_CHECK_EN
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            exp_q <= STG_IF;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_seq_issuer.sv
// Scoreboard bench for seq_issuer: a driver pushes the expected done event per request, a monitor checks each done pulse.
module tb_seq_issuer;
    localparam int CNT_W = 8;

    logic             m_clock = 1'b0;
    logic             p_reset = 1'b1;
    logic             req_valid = 1'b0;
    logic [CNT_W-1:0] req_count = '0;
    logic             req_ready;
    logic [2:0]       state_in = 3'd0;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] retired;
    logic             err;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int cyc;
        int ret;
        int err;
    } exp_t;
    exp_t sb_q[$];

    // Behavioural sequencer controls (written by the driver, read by the sequencer model).
    int       seq_n = 0;
    int       bad_pos = -1;
    logic [2:0] bad_code = 3'd0;
    int       seq_left = 0;
    int       seq_pos = 0;

    seq_issuer #(.CNT_W(CNT_W)) dut (
        .m_clock  (m_clock),
        .p_reset  (p_reset),
        .req_valid(req_valid),
        .req_count(req_count),
        .req_ready(req_ready),
        .state_in (state_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .retired  (retired),
        .err      (err)
    );

    always #5 m_clock = ~m_clock;

    always @(posedge m_clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Sequencer model: after seeing start, plays seq_n instructions of IF..WB, optionally corrupting one slot.
    always @(negedge m_clock) begin
        if (p_reset) begin
            seq_left = 0;
            state_in = 3'd0;
        end else if (start) begin
            seq_left = seq_n * 5;
            seq_pos  = 0;
            state_in = 3'd0;
        end else if (seq_left > 0) begin
            state_in = 3'((seq_pos % 5) + 1);
            if (seq_pos == bad_pos) state_in = bad_code;
            seq_pos++;
            seq_left--;
        end else begin
            state_in = 3'd0;
        end
    end

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge m_clock) begin
        exp_t e;
        if (!p_reset && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done at cycle %0d, required no pending run", cyc);
            end else begin
                e = sb_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_retired", int'(retired), e.ret);
                check("done_err", int'(err), e.err);
                check("done_busy", int'(busy), 0);
            end
        end
    end

    // Called at a negedge; presents the request for one edge and returns at the following negedge.
    task automatic run_req(input int n, input int extra, input int bpos, input int bcode,
                           input int lat, input int eret, input int eerr, output int acc);
        exp_t e;
        check("req_ready_before", int'(req_ready), 1);
        seq_n     = n + extra;
        bad_pos   = bpos;
        bad_code  = 3'(bcode);
        req_count = CNT_W'(n);
        req_valid = 1'b1;
        acc       = cyc + 1;
        e.cyc = acc + lat;
        e.ret = eret;
        e.err = eerr;
        sb_q.push_back(e);
        @(negedge m_clock);
        req_valid = 1'b0;
        check("start_after_accept", int'(start), (n != 0) ? 1 : 0);
        check("busy_after_accept", int'(busy), (n != 0) ? 1 : 0);
        check("ready_after_accept", int'(req_ready), (n != 0) ? 0 : 1);
        check("retired_cleared", int'(retired), 0);
        check("err_cleared", int'(err), 0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            @(negedge m_clock);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got %0d runs outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge m_clock);
    endtask

    initial begin
        int acc;
        int k;
        int exp_err_ill;
        int exp_lat_ill;
        int exp_ret_ill;

        #12;
        check("rst_start", int'(start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_retired", int'(retired), 0);
        check("rst_ready", int'(req_ready), 1);
        @(negedge m_clock);
        p_reset = 1'b0;
        repeat (2) @(negedge m_clock);

        // Single instruction: done 6 cycles after accept.
        run_req(1, 0, -1, 0, 6, 1, 0, acc);
        wait_idle();

        // Four instructions plus one extra that must not be counted.
        run_req(4, 1, -1, 0, 21, 4, 0, acc);
        wait_idle();
        repeat (8) @(negedge m_clock);
        check("retired_hold", int'(retired), 4);
        check("no_done_after", int'(done), 0);

        // Zero count: done immediately, no start.
        run_req(0, 0, -1, 0, 0, 0, 0, acc);
        wait_idle();

        // Back-to-back: second request presented during the done cycle of the first.
        run_req(3, 0, -1, 0, 16, 3, 0, acc);
        k = 0;
        while (cyc < acc + 16 && k < 100) begin
            @(negedge m_clock);
            k++;
        end
        check("b2b_done_cycle", int'(done), 1);
        run_req(2, 0, -1, 0, 11, 2, 0, acc);
        wait_idle();
        repeat (2) @(negedge m_clock);

        // Illegal transition: RF driven where DE is expected.
`ifdef SEQ_ISSUER_CHECK_EN
        exp_lat_ill = 3;
        exp_ret_ill = 0;
        exp_err_ill = 1;
`else
        exp_lat_ill = 11;
        exp_ret_ill = 2;
        exp_err_ill = 0;
`endif
        run_req(2, 0, 1, 3, exp_lat_ill, exp_ret_ill, exp_err_ill, acc);
        wait_idle();
        repeat (12) @(negedge m_clock);
        check("err_sticky", int'(err), exp_err_ill);
        run_req(1, 0, -1, 0, 6, 1, 0, acc);
        wait_idle();

        // Reset in the middle of a three-instruction run, after the first WB.
        run_req(3, 0, -1, 0, 16, 3, 0, acc);
        repeat (7) @(negedge m_clock);
        check("pre_rst_retired", int'(retired), 1);
        #2 p_reset = 1'b1;
        #1;
        check("mid_rst_start", int'(start), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_retired", int'(retired), 0);
        sb_q.delete();
        repeat (2) @(negedge m_clock);
        p_reset = 1'b0;
        @(negedge m_clock);
        check("post_rst_ready", int'(req_ready), 1);
        check("post_rst_busy", int'(busy), 0);
        run_req(1, 0, -1, 0, 6, 1, 0, acc);
        wait_idle();

        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
